pmem_arbiter: RTL and testbench
===============================

Name: pmem_arbiter

Overview:
- Shares the single physical memory port between the instruction cache miss path and the data cache miss path.
- Sits between the two caches' pmem-side interfaces and physical memory.
- Grants one requester at a time, latches that requester's command, holds it until memory responds, then routes the response back to the granted requester only.

Parameters:
ADDR_W, 16, physical address width (lc3b_word)
LINE_W, 128, cache line width in bits

Ports:
clk  in  1  system clock
reset  in  1  synchronous active-high reset
i_pmem_read  in  1  icache line-fill request
i_pmem_address  in  ADDR_W  icache line address
i_pmem_rdata  out  LINE_W  line data to icache
i_pmem_resp  out  1  icache transaction complete
d_pmem_read  in  1  dcache line-fill request
d_pmem_write  in  1  dcache writeback request
d_pmem_address  in  ADDR_W  dcache line address
d_pmem_wdata  in  LINE_W  dcache writeback data
d_pmem_rdata  out  LINE_W  line data to dcache
d_pmem_resp  out  1  dcache transaction complete
pmem_read  out  1  memory read command
pmem_write  out  1  memory write command
pmem_address  out  ADDR_W  memory address
pmem_wdata  out  LINE_W  memory write data
pmem_rdata  in  LINE_W  memory read data
pmem_resp  in  1  memory transaction complete

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high, named reset.
- Reset values:
  - state = IDLE
  - pmem_read = 0, pmem_write = 0
  - pmem_address = 0, pmem_wdata = 0
  - i_pmem_resp = 0, d_pmem_resp = 0
- FSM states: IDLE, I_BUSY, D_BUSY.
- IDLE:
  - Samples requests each edge. A requester is pending if i_pmem_read, or d_pmem_read | d_pmem_write, is asserted.
  - Only icache pending -> I_BUSY.
  - Only dcache pending -> D_BUSY.
  - Both pending -> winner chosen by the priority rule; loser stays pending.
  - On the grant edge, the arbiter registers the winner's address, wdata and op into the pmem_* outputs.
  - icache grant: pmem_wdata = 0.
  - dcache with both read and write asserted: write wins.
- Latency: request seen at edge N -> pmem command asserted after edge N (cycle N+1).
- I_BUSY / D_BUSY:
  - pmem_* outputs are held constant until pmem_resp = 1.
  - The cycle pmem_resp = 1, the owner's *_pmem_resp = pmem_resp (combinational pass-through, gated by state).
  - The next edge clears pmem_read/pmem_write and returns to IDLE.
- Turnaround: at least one IDLE cycle between consecutive memory transactions. Back-to-back requests cost resp + 1 idle + command.
- Read data: pmem_rdata is broadcast to both i_pmem_rdata and d_pmem_rdata. Only the gated resp qualifies it.
- Non-owner resp: never asserted. The resp of the requester not being served is always 0.
- Requester drops its request mid-transaction: ignored. The latched command completes, and the resp pulse is still issued to that requester.
- pmem_resp while in IDLE (stale or spurious): ignored. No resp is forwarded.
- Reset mid-transaction:
  - Returns to IDLE and clears commands on that edge.
  - A later pmem_resp for the aborted transaction is ignored.
- Default priority: dcache wins simultaneous requests (fixed priority).

Optional Feature:
PMEM_ARB_RR_EN
- Defined: a 1-bit last_grant register (reset = 0, meaning icache last) selects the winner on contention.
  - Winner is the requester NOT granted last. last_grant updates on every grant.
  - Guarantees an icache fill is never starved by consecutive dcache misses.
- Undefined: fixed dcache priority; no last_grant register.

Decomposition:
- Shared package lc3b_types (existing) gains:
  - lc3b_line (LINE_W-bit)
  - pmem_arb_state_t enum {IDLE, I_BUSY, D_BUSY}
  - pmem_op_t enum {OP_READ, OP_WRITE}
- Natural sub-module: pmem_arb_priority (combinational winner select from i_pend, d_pend, last_grant).
- FSM and command registers stay in pmem_arbiter.

Test Plan:
1. Icache only:
   - Stimulus: i_pmem_read = 1, addr 16'h0040; memory asserts pmem_resp 3 cycles after the command.
   - Required: pmem_read = 1 at cycle N+1 with pmem_address = 16'h0040; i_pmem_resp pulses for exactly 1 cycle; d_pmem_resp stays 0; pmem_read = 0 the next cycle.
2. Dcache writeback:
   - Stimulus: d_pmem_write = 1, addr 16'h1230, wdata 128'hDEAD...BEEF.
   - Required: pmem_write = 1 with matching address and data held stable until resp; d_pmem_resp is 1 cycle wide.
3. Simultaneous requests:
   - Stimulus: i addr 16'h0100 and d read addr 16'h2000 asserted in the same cycle.
   - Required (fixed priority): dcache served first, then one IDLE cycle, then icache served.
   - Required (PMEM_ARB_RR_EN defined, after reset): dcache first (last_grant = icache). Repeat contention -> icache wins.
4. Dcache read+write asserted together:
   - Required: pmem_write = 1, pmem_read = 0.
5. Reset mid-transaction:
   - Stimulus: reset during D_BUSY, then pmem_resp arrives 2 cycles later.
   - Required: commands cleared on the reset edge; no d_pmem_resp or i_pmem_resp pulse.
6. Requester drops mid-transaction:
   - Stimulus: i_pmem_read deasserted while in I_BUSY.
   - Required: pmem_address is unchanged; i_pmem_resp still pulses on pmem_resp.

Source files
------------

// File: rtl/lc3b_types.sv
// Shared LC-3b types used by the cache/memory side of the core, including the
// line type and the enums used by the physical-memory arbiter.
package lc3b_types;

  localparam int LC3B_ADDR_W = 16;
  localparam int LC3B_LINE_W = 128;

  typedef logic [LC3B_ADDR_W-1:0] lc3b_word;
  typedef logic [LC3B_LINE_W-1:0] lc3b_line;

  typedef enum logic [1:0] {
    IDLE,
    I_BUSY,
    D_BUSY
  } pmem_arb_state_t;

  typedef enum logic {
    OP_READ,
    OP_WRITE
  } pmem_op_t;

endpackage

// File: rtl/pmem_arb_priority.sv
// Combinational winner select between the icache and dcache miss paths.
// last_grant: 0 = icache was granted last, 1 = dcache was granted last.
module pmem_arb_priority (
  input  logic i_pend,
  input  logic d_pend,
  input  logic last_grant,
  output logic grant_i,
  output logic grant_d
);

  // On contention the requester that was not granted last wins; with
  // last_grant tied low this degenerates to fixed dcache priority.
  assign grant_d = d_pend & (~i_pend | ~last_grant);
  assign grant_i = i_pend & (~d_pend |  last_grant);

endmodule

// File: rtl/pmem_arbiter.sv
// Shares the physical memory port between the icache and dcache miss paths.
// Optional PMEM_ARB_RR_EN: round-robin on contention instead of fixed dcache priority.
module pmem_arbiter
  import lc3b_types::*;
#(
  parameter int ADDR_W = LC3B_ADDR_W,
  parameter int LINE_W = LC3B_LINE_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  pmem_arb_state_t   state_q, state_d;
  logic              cmd_valid_q, cmd_valid_d;
  pmem_op_t          op_q, op_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0] wdata_q, wdata_d;

  logic i_pend, d_pend;
  logic grant_i, grant_d;
  logic last_grant;

  assign i_pend = i_pmem_read;
  assign d_pend = d_pmem_read | d_pmem_write;

  pmem_arb_priority u_priority (
    .i_pend     (i_pend),
    .d_pend     (d_pend),
    .last_grant (last_grant),
    .grant_i    (grant_i),
    .grant_d    (grant_d)
  );

`ifdef PMEM_ARB_RR_EN
  logic last_grant_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      last_grant_q <= 1'b0;
    end else if (state_q == IDLE && (grant_i | grant_d)) begin
      last_grant_q <= grant_d;
    end
  end

  assign last_grant = last_grant_q;
`else
  assign last_grant = 1'b0;
`endif

  // State and command registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      cmd_valid_q <= 1'b0;
      op_q        <= OP_READ;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
    end
  end

  // Next state: the command is latched on the grant edge and held until pmem_resp.
  always_comb begin
    state_d     = state_q;
    cmd_valid_d = cmd_valid_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          state_d     = D_BUSY;
          cmd_valid_d = 1'b1;
          op_d        = d_pmem_write ? OP_WRITE : OP_READ;
          addr_d      = d_pmem_address;
          wdata_d     = d_pmem_wdata;
        end else if (grant_i) begin
          state_d     = I_BUSY;
          cmd_valid_d = 1'b1;
          op_d        = OP_READ;
          addr_d      = i_pmem_address;
          wdata_d     = '0;
        end
      end
      I_BUSY, D_BUSY: begin
        if (pmem_resp) begin
          state_d     = IDLE;
          cmd_valid_d = 1'b0;
        end
      end
      default: begin
        state_d     = IDLE;
        cmd_valid_d = 1'b0;
      end
    endcase
  end

  // Outputs: responses only reach the current owner; read data is broadcast.
  always_comb begin
    pmem_read    = cmd_valid_q & (op_q == OP_READ);
    pmem_write   = cmd_valid_q & (op_q == OP_WRITE);
    pmem_address = addr_q;
    pmem_wdata   = wdata_q;
    i_pmem_resp  = (state_q == I_BUSY) & pmem_resp;
    d_pmem_resp  = (state_q == D_BUSY) & pmem_resp;
    i_pmem_rdata = pmem_rdata;
    d_pmem_rdata = pmem_rdata;
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: directed vector table, hand-written corner sequences,
// and randomized traffic checked against a transaction-level memory-port model.
module tb_pmem_arbiter;

`ifdef PMEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         reset;
  logic         i_pmem_read;
  logic [15:0]  i_pmem_address;
  logic [127:0] i_pmem_rdata;
  logic         i_pmem_resp;
  logic         d_pmem_read;
  logic         d_pmem_write;
  logic [15:0]  d_pmem_address;
  logic [127:0] d_pmem_wdata;
  logic [127:0] d_pmem_rdata;
  logic         d_pmem_resp;
  logic         pmem_read;
  logic         pmem_write;
  logic [15:0]  pmem_address;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;

  int n_checks = 0;
  int n_pass   = 0;

  pmem_arbiter dut (
    .clk            (clk),
    .reset          (reset),
    .i_pmem_read    (i_pmem_read),
    .i_pmem_address (i_pmem_address),
    .i_pmem_rdata   (i_pmem_rdata),
    .i_pmem_resp    (i_pmem_resp),
    .d_pmem_read    (d_pmem_read),
    .d_pmem_write   (d_pmem_write),
    .d_pmem_address (d_pmem_address),
    .d_pmem_wdata   (d_pmem_wdata),
    .d_pmem_rdata   (d_pmem_rdata),
    .d_pmem_resp    (d_pmem_resp),
    .pmem_read      (pmem_read),
    .pmem_write     (pmem_write),
    .pmem_address   (pmem_address),
    .pmem_wdata     (pmem_wdata),
    .pmem_rdata     (pmem_rdata),
    .pmem_resp      (pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic         i_rd;
    logic         d_rd;
    logic         d_wr;
    logic [15:0]  i_addr;
    logic [15:0]  d_addr;
    logic [127:0] d_wdata;
    int           lat;
    int           own;      // 1 = icache, 2 = dcache
    logic         exp_rd;
    logic         exp_wr;
    logic [15:0]  exp_addr;
    logic [127:0] exp_wdata;
    int           own2;     // loser served afterwards, 0 = none
    logic [15:0]  addr2;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_resp = 1'b0; pmem_rdata = '0;
    @(negedge clk);
    @(negedge clk); #1;
    chk("rst_pmem_read", 128'(pmem_read), 128'(0));
    chk("rst_pmem_write", 128'(pmem_write), 128'(0));
    chk("rst_pmem_address", 128'(pmem_address), 128'(0));
    chk("rst_pmem_wdata", pmem_wdata, 128'(0));
    chk("rst_resps", 128'({i_pmem_resp, d_pmem_resp}), 128'(0));
    reset = 1'b0;
  endtask

  // Called just after the negedge of the first command cycle; returns in the idle cycle after resp.
  task automatic serve(input int owner, input logic rd, input logic wr, input logic [15:0] addr,
                       input logic [127:0] wd, input int lat, input string tag);
    logic [127:0] rdat;
    for (int c = 0; c < lat; c++) begin
      if (c > 0) begin @(negedge clk); #1; end
      chk({tag, "_read"}, 128'(pmem_read), 128'(rd));
      chk({tag, "_write"}, 128'(pmem_write), 128'(wr));
      chk({tag, "_addr"}, 128'(pmem_address), 128'(addr));
      chk({tag, "_wdata"}, pmem_wdata, wd);
      chk({tag, "_early_resp"}, 128'({i_pmem_resp, d_pmem_resp}), 128'(0));
    end
    @(negedge clk);
    rdat = {$urandom, $urandom, $urandom, $urandom};
    pmem_rdata = rdat;
    pmem_resp = 1'b1;
    #1;
    chk({tag, "_addr_at_resp"}, 128'(pmem_address), 128'(addr));
    chk({tag, "_i_resp"}, 128'(i_pmem_resp), 128'(owner == 1));
    chk({tag, "_d_resp"}, 128'(d_pmem_resp), 128'(owner == 2));
    chk({tag, "_rdata"}, (owner == 1) ? i_pmem_rdata : d_pmem_rdata, rdat);
    if (owner == 1) i_pmem_read = 1'b0;
    else begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk({tag, "_cleared"}, 128'({pmem_read, pmem_write}), 128'(0));
    chk({tag, "_resp_one_cycle"}, 128'({i_pmem_resp, d_pmem_resp}), 128'(0));
    $display("txn %s owner=%0d addr=%h rd=%0d wr=%0d lat=%0d", tag, owner, addr, rd, wr, lat);
  endtask

  // Transaction-level model of the memory port for the random phase.
  int           m_owner;
  logic         m_rd, m_wr;
  logic [15:0]  m_addr;
  logic [127:0] m_wdata;
  bit           m_last_d;
  int           mem_cnt, mem_lat;

  initial begin
    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h0040, 16'h0000, 128'h0, 3,
                1, 1'b1, 1'b0, 16'h0040, 128'h0, 0, 16'h0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h1230, 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF, 3,
                2, 1'b0, 1'b1, 16'h1230, 128'hDEAD_1111_2222_3333_4444_5555_6666_BEEF, 0, 16'h0};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0100, 16'h2000, 128'h0, 2,
                2, 1'b1, 1'b0, 16'h2000, 128'h0, 1, 16'h0100};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h3330, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 1,
                2, 1'b0, 1'b1, 16'h3330, 128'h0123_4567_89AB_CDEF_0F1E_2D3C_4B5A_6978, 0, 16'h0};
    vecs[4] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h4440, 128'h0, 4,
                2, 1'b1, 1'b0, 16'h4440, 128'h0, 0, 16'h0};
    vecs[5] = '{1'b1, 1'b0, 1'b0, 16'h7770, 16'h0000, 128'hFFFF_0000_FFFF_0000_FFFF_0000_FFFF_0000, 2,
                1, 1'b1, 1'b0, 16'h7770, 128'h0, 0, 16'h0};

    for (int v = 0; v < 6; v++) begin
      do_reset();
      i_pmem_read = vecs[v].i_rd;  i_pmem_address = vecs[v].i_addr;
      d_pmem_read = vecs[v].d_rd;  d_pmem_write = vecs[v].d_wr;
      d_pmem_address = vecs[v].d_addr;  d_pmem_wdata = vecs[v].d_wdata;
      @(negedge clk); #1;
      serve(vecs[v].own, vecs[v].exp_rd, vecs[v].exp_wr, vecs[v].exp_addr, vecs[v].exp_wdata,
            vecs[v].lat, $sformatf("vec%0d", v));
      if (vecs[v].own2 != 0) begin
        @(negedge clk); #1;
        serve(vecs[v].own2, 1'b1, 1'b0, vecs[v].addr2, 128'h0, 2, $sformatf("vec%0d_second", v));
      end
    end

    // Repeated contention: dcache re-requests in the idle cycle while icache is still waiting.
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 16'h0100;
    d_pmem_read = 1'b1; d_pmem_address = 16'h2000;
    @(negedge clk); #1;
    serve(2, 1'b1, 1'b0, 16'h2000, 128'h0, 2, "cont_first");
    d_pmem_read = 1'b1; d_pmem_address = 16'h2200;
    @(negedge clk); #1;
    if (RR) begin
      serve(1, 1'b1, 1'b0, 16'h0100, 128'h0, 2, "cont_rr_i");
      @(negedge clk); #1;
      serve(2, 1'b1, 1'b0, 16'h2200, 128'h0, 2, "cont_rr_d");
    end else begin
      serve(2, 1'b1, 1'b0, 16'h2200, 128'h0, 2, "cont_fix_d");
      @(negedge clk); #1;
      serve(1, 1'b1, 1'b0, 16'h0100, 128'h0, 2, "cont_fix_i");
    end

    // Reset during D_BUSY, stale response afterwards, then recovery.
    do_reset();
    d_pmem_read = 1'b1; d_pmem_address = 16'h5550;
    @(negedge clk); #1;
    chk("abort_cmd_up", 128'(pmem_read), 128'(1));
    reset = 1'b1; d_pmem_read = 1'b0;
    @(negedge clk); #1;
    chk("abort_cleared", 128'({pmem_read, pmem_write}), 128'(0));
    chk("abort_addr", 128'(pmem_address), 128'(0));
    reset = 1'b0;
    @(negedge clk);
    pmem_resp = 1'b1; pmem_rdata = 128'h5A5A;
    #1;
    chk("stale_resp", 128'({i_pmem_resp, d_pmem_resp}), 128'(0));
    @(negedge clk);
    pmem_resp = 1'b0;
    #1;
    chk("stale_idle", 128'({pmem_read, pmem_write}), 128'(0));
    i_pmem_read = 1'b1; i_pmem_address = 16'h5670;
    @(negedge clk); #1;
    serve(1, 1'b1, 1'b0, 16'h5670, 128'h0, 2, "after_abort");

    // Icache drops its request right after the grant.
    do_reset();
    i_pmem_read = 1'b1; i_pmem_address = 16'h6660;
    @(negedge clk); #1;
    i_pmem_read = 1'b0; i_pmem_address = 16'hFFF0;
    serve(1, 1'b1, 1'b0, 16'h6660, 128'h0, 3, "drop");

    // Randomized traffic.
    do_reset();
    m_owner = 0; m_rd = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    m_last_d = 1'b0; mem_cnt = 0; mem_lat = 1;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      logic resp;
      logic [127:0] rdat;
      bit ip, dp;
      int win;
      @(negedge clk);
      if (m_owner != 0) begin
        mem_cnt++;
        resp = (mem_cnt >= mem_lat);
      end else begin
        resp = ($urandom_range(0, 19) == 0);
      end
      rdat = {$urandom, $urandom, $urandom, $urandom};
      pmem_resp = resp; pmem_rdata = rdat;
      #1;
      chk("rnd_read", 128'(pmem_read), 128'(m_owner != 0 && m_rd));
      chk("rnd_write", 128'(pmem_write), 128'(m_owner != 0 && m_wr));
      if (m_owner != 0) begin
        chk("rnd_addr", 128'(pmem_address), 128'(m_addr));
        chk("rnd_wdata", pmem_wdata, m_wdata);
      end
      chk("rnd_i_resp", 128'(i_pmem_resp), 128'(m_owner == 1 && resp));
      chk("rnd_d_resp", 128'(d_pmem_resp), 128'(m_owner == 2 && resp));
      chk("rnd_rdata", {i_pmem_rdata ^ d_pmem_rdata}, 128'(0) ^ (rdat ^ rdat));
      if (resp && m_owner != 0)
        chk("rnd_rdata_val", (m_owner == 1) ? i_pmem_rdata : d_pmem_rdata, rdat);

      // Caches: release on own resp, occasionally abandon, otherwise maybe issue a new miss.
      if (m_owner == 1 && resp) i_pmem_read = 1'b0;
      else if (i_pmem_read && $urandom_range(0, 39) == 0) i_pmem_read = 1'b0;
      else if (!i_pmem_read && $urandom_range(0, 2) == 0) begin
        i_pmem_read = 1'b1;
        i_pmem_address = 16'($urandom) & 16'hFFF0;
      end
      if (m_owner == 2 && resp) begin d_pmem_read = 1'b0; d_pmem_write = 1'b0; end
      else if (!(d_pmem_read || d_pmem_write) && $urandom_range(0, 2) == 0) begin
        int op;
        op = $urandom_range(0, 2);
        d_pmem_read  = (op != 1);
        d_pmem_write = (op != 0);
        d_pmem_address = 16'($urandom) & 16'hFFF0;
        d_pmem_wdata = {$urandom, $urandom, $urandom, $urandom};
      end
      reset = ($urandom_range(0, 149) == 0);

      // What the memory port should carry after the coming edge.
      if (reset) begin
        m_owner = 0; m_rd = 1'b0; m_wr = 1'b0; m_last_d = 1'b0;
      end else if (m_owner != 0) begin
        if (resp) begin m_owner = 0; m_rd = 1'b0; m_wr = 1'b0; end
      end else begin
        ip = i_pmem_read;
        dp = d_pmem_read || d_pmem_write;
        if (ip && dp) win = (RR && m_last_d) ? 1 : 2;
        else if (ip) win = 1;
        else if (dp) win = 2;
        else win = 0;
        if (win == 1) begin
          m_owner = 1; m_rd = 1'b1; m_wr = 1'b0; m_addr = i_pmem_address; m_wdata = '0;
        end else if (win == 2) begin
          m_owner = 2; m_wr = d_pmem_write; m_rd = !d_pmem_write;
          m_addr = d_pmem_address; m_wdata = d_pmem_wdata;
        end
        if (win != 0) begin
          m_last_d = (win == 2);
          mem_cnt = 0;
          mem_lat = $urandom_range(1, 4);
        end
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
